loop_sequencer: RTL and testbench
=================================

Name: loop_sequencer

Overview:
- Two-level loop controller that sequences a pair of loadable up-counters (inner, outer) to walk an index space for the datapath.
- Emits one step per (outer, inner) index pair on a valid/ready handshake and reports completion.
- Sits between the top-level control (start/done) and any datapath stage that consumes per-step indices (memory address generation, per-cell processing).

Parameters:
- N, 6, width of each index counter; each loop runs from its init value up to all-ones inclusive.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a sweep; honoured only in IDLE.
- inner_init  input  N  inner loop start value, sampled on accepted start.
- outer_init  input  N  outer loop start value, sampled on accepted start.
- step_ready  input  1  datapath accepts the current step.
- step_valid  output  1  current indices are valid.
- inner_idx  output  N  current inner index.
- outer_idx  output  N  current outer index.
- row_first  output  1  high while the current step is the first inner step of an outer iteration.
- busy  output  1  high in LOAD and RUN.
- done  output  1  one-cycle pulse after the last step is accepted.

Behaviour:
- Reset: the reset is asynchronous, active-high, on rst; the clock is clk. On reset: state=IDLE; both counters=0; inner_base register=0; step_valid=0, busy=0, done=0, row_first=0; inner_idx=0, outer_idx=0.
- FSM states and transitions:
  - IDLE: start=1 -> LOAD.
  - LOAD: both counters loaded, inner_init captured into inner_base -> RUN.
  - RUN: stays until the final handshake -> DONE.
  - DONE: -> IDLE unconditionally.
- Latency: with start sampled at edge t, the first step_valid=1 appears in the cycle after edge t+1.
- Handshake: in RUN, step_valid=1.
  - A step completes on a cycle where step_valid && step_ready.
  - While step_ready=0, inner_idx, outer_idx and row_first hold stable.
- Step advance on handshake:
  - inner != all-ones: inner+1.
  - inner == all-ones, outer != all-ones: inner reloads inner_base, outer+1.
  - Both all-ones: -> DONE; counters hold.
- Counter semantics: load has priority over enable; carry = en & (&count). The outer counter is enabled by the handshake AND inner carry.
- Width rules:
  - No counter ever wraps past all-ones inside a sweep.
  - Total steps = (2^N - inner_init) * (2^N - outer_init).
- row_first: 1 in the first RUN cycle, and after every inner reload, until the next handshake.
- done: high only in the DONE state (exactly 1 cycle). busy=0 in IDLE and DONE.
- Boundary conditions:
  - start outside IDLE, including the DONE cycle: ignored.
  - inner_init=all-ones: one inner step per outer iteration.
  - Both inits all-ones: exactly one step.
  - rst mid-RUN: step_valid drops immediately (asynchronous); state returns to IDLE; no done pulse.
  - step_ready high outside RUN: no effect.

Optional Feature:
- Macro LOOP_SEQ_ABORT_EN.
- When defined:
  - Adds input abort (1 bit).
  - abort=1 in LOAD or RUN -> DONE next edge. This takes precedence over any concurrent handshake, which is not counted.
  - Adds output aborted (1 bit). It pulses together with done on that exit and stays 0 on normal completion.
- When undefined: neither port exists; behaviour is exactly as above.

Decomposition:
- Package loop_seq_pkg:
  - State typedef (IDLE, LOAD, RUN, DONE), 2-bit encoding.
  - Default width constant LOOP_SEQ_N=6.
- Sub-module step_counter:
  - Parameter N; ports clk, rst, en, ld, init, count, co.
  - Asynchronous reset to 0; ld has priority over en; co = en & (&count).
  - Instantiated twice, inner and outer.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 immediately; state IDLE.
- N=6, inner_init=62, outer_init=61, step_ready=1 -> 6 steps (outer,inner): (61,62),(61,63),(62,62),(62,63),(63,62),(63,63).
  - row_first is high on steps 1, 3 and 5.
  - done pulses 1 cycle after the 6th handshake.
- inner_init=63, outer_init=63 -> exactly one step (63,63), then done; busy high for 2 cycles.
- Same as the 6-step case with step_ready toggling 0/1 each cycle -> same 6-step sequence; indices stable while ready=0; done after the 12th RUN cycle.
- start pulsed during RUN and during the DONE cycle -> ignored. A new start in IDLE reloads fresh inits; 4 steps for 62/62.
- rst asserted after the 3rd handshake of the 6-step case -> step_valid=0 immediately, no done. A following start produces the full sequence again.
- With LOOP_SEQ_ABORT_EN: abort on the 2nd RUN cycle with ready=1 -> only 1 step counted; done=1 and aborted=1 on the next cycle.

Source files
------------

// File: rtl/loop_seq_pkg.sv
// loop_seq_pkg: shared state encoding and default index width for loop_sequencer.
package loop_seq_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
   localparam int LOOP_SEQ_N = 6;
endpackage

// File: rtl/loop_sequencer_step_counter.sv
// step_counter: loadable up-counter; load beats enable, carry when enabled at all-ones.
module step_counter #(
   parameter int N = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         ld,
   input  logic [N-1:0] init,
   output logic [N-1:0] count,
   output logic         co
);
   assign co = en & (&count);
   always_ff @(posedge clk or posedge rst)
      if (rst) count <= '0;
      else if (ld) count <= init;
      else if (en) count <= count + 1'b1;
endmodule

// File: rtl/loop_sequencer.sv
// loop_sequencer: two-level (outer, inner) index sweep issued as valid/ready steps.
// Optional abort input/aborted output when LOOP_SEQ_ABORT_EN is defined.
module loop_sequencer
   import loop_seq_pkg::*;
#(
   parameter int N = LOOP_SEQ_N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] inner_init,
   input  logic [N-1:0] outer_init,
   input  logic         step_ready,
   output logic         step_valid,
   output logic [N-1:0] inner_idx,
   output logic [N-1:0] outer_idx,
   output logic         row_first,
   output logic         busy,
`ifdef LOOP_SEQ_ABORT_EN
   input  logic         abort,
   output logic         aborted,
`endif
   output logic         done
);
   state_t       state_q, state_d;
   logic [N-1:0] inner_base_q, inner_ld_val, outer_ld_val;
   logic         row_first_q, row_first_d;
   logic         is_load, is_run, hs, abort_w;
   logic         inner_co, outer_co;
   assign is_load = state_q == LOAD;
   assign is_run  = state_q == RUN;
`ifdef LOOP_SEQ_ABORT_EN
   logic aborted_q;
   assign abort_w = abort & (is_load | is_run);
   assign aborted = aborted_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) aborted_q <= 1'b0;
      else aborted_q <= abort_w;
`else
   assign abort_w = 1'b0;
`endif
   assign hs = is_run & step_ready & ~abort_w;
   // Outer carry marks the final step: both counters reload themselves so they hold.
   assign inner_ld_val = is_load ? inner_init : outer_co ? inner_idx : inner_base_q;
   assign outer_ld_val = is_load ? outer_init : outer_idx;
   step_counter #(.N(N)) u_inner (
      .clk(clk), .rst(rst), .en(hs), .ld(is_load | inner_co),
      .init(inner_ld_val), .count(inner_idx), .co(inner_co)
   );
   step_counter #(.N(N)) u_outer (
      .clk(clk), .rst(rst), .en(inner_co), .ld(is_load | outer_co),
      .init(outer_ld_val), .count(outer_idx), .co(outer_co)
   );
   always_comb begin
      state_d     = abort_w ? DONE
                  : state_q == IDLE ? (start ? LOAD : IDLE)
                  : is_load ? RUN
                  : is_run ? (outer_co ? DONE : RUN)
                  : IDLE;
      row_first_d = (is_load & ~abort_w) | (inner_co & ~outer_co) | (row_first_q & ~hs & ~abort_w);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q      <= IDLE;
         row_first_q  <= 1'b0;
         inner_base_q <= '0;
      end else begin
         state_q     <= state_d;
         row_first_q <= row_first_d;
         if (is_load) inner_base_q <= inner_init;
      end
   assign step_valid = is_run;
   assign busy       = is_load | is_run;
   assign done       = state_q == DONE;
   assign row_first  = row_first_q;
endmodule

// File: tb/tb_loop_sequencer.sv
// tb_loop_sequencer: scoreboard bench; expected (outer, inner, row_first) steps are queued
// by the stimulus and popped by a negedge monitor on every accepted step.
module tb_loop_sequencer;
   logic       clk = 1'b0, rst = 1'b1, start = 1'b0, step_ready = 1'b0;
   logic [5:0] inner_init = '0, outer_init = '0;
   logic       step_valid, row_first, busy, done, ab_in;
   logic [5:0] inner_idx, outer_idx;
   logic [12:0] sb[$];
   logic [12:0] held;
   bit          stall = 1'b0;
   int          n_chk = 0, n_fail = 0, n_hs = 0;
`ifdef LOOP_SEQ_ABORT_EN
   logic abort = 1'b0, aborted;
   assign ab_in = abort;
`else
   assign ab_in = 1'b0;
`endif

   loop_sequencer #(.N(6)) dut (
      .clk(clk), .rst(rst), .start(start), .inner_init(inner_init), .outer_init(outer_init),
      .step_ready(step_ready), .step_valid(step_valid), .inner_idx(inner_idx),
      .outer_idx(outer_idx), .row_first(row_first), .busy(busy),
`ifdef LOOP_SEQ_ABORT_EN
      .abort(abort), .aborted(aborted),
`endif
      .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst || !step_valid) stall = 1'b0;
      else begin
         if (stall) chk("stall_hold", {19'd0, outer_idx, inner_idx, row_first}, {19'd0, held});
         if (step_ready && !ab_in) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_step: got step %0h expected none", {outer_idx, inner_idx, row_first});
            end else chk("step", {19'd0, outer_idx, inner_idx, row_first}, {19'd0, sb.pop_front()});
            n_hs++;
         end
         stall = !step_ready;
         held  = {outer_idx, inner_idx, row_first};
      end
   end

   task automatic push6();
      sb.push_back({6'd61, 6'd62, 1'b1}); sb.push_back({6'd61, 6'd63, 1'b0});
      sb.push_back({6'd62, 6'd62, 1'b1}); sb.push_back({6'd62, 6'd63, 1'b0});
      sb.push_back({6'd63, 6'd62, 1'b1}); sb.push_back({6'd63, 6'd63, 1'b0});
   endtask

   task automatic sweep(input logic [5:0] ii, input logic [5:0] oi, input bit tog, input bit poke,
                        input int exp_run, input int exp_busy, input string nm);
      int  runs = 0, busys = 0;
      bit  seen = 1'b0;
      @(posedge clk); #1;
      inner_init = ii; outer_init = oi; start = 1'b1; step_ready = !tog;
      for (int c = 0; c < 200 && !seen; c++) begin
         @(posedge clk); #1;
         start = poke && c == 3;
         step_ready = tog ? ~step_ready : 1'b1;
         @(negedge clk);
         runs  += int'(step_valid);
         busys += int'(busy);
         if (done) begin
            seen = 1'b1;
`ifdef LOOP_SEQ_ABORT_EN
            chk({nm, "_aborted_low"}, {31'd0, aborted}, 32'd0);
`endif
            if (poke) start = 1'b1;
         end
      end
      chk({nm, "_done_seen"}, {31'd0, seen}, 32'd1);
      chk({nm, "_run_cycles"}, runs, exp_run);
      chk({nm, "_busy_cycles"}, busys, exp_busy);
      chk({nm, "_queue_empty"}, sb.size(), 0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk({nm, "_done_one_cycle"}, {31'd0, done}, 32'd0);
      chk({nm, "_idle_after"}, {30'd0, busy, step_valid}, 32'd0);
   endtask

   initial begin
      #2;
      chk("reset_outputs", {19'd0, step_valid, busy, done, row_first, inner_idx, outer_idx}, 32'd0);
      @(negedge clk); rst = 1'b0;
      step_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("ready_idle_no_effect", {30'd0, busy, step_valid}, 32'd0);

      push6();
      sweep(6'd62, 6'd61, 1'b0, 1'b0, 6, 7, "six");
      sb.push_back({6'd63, 6'd63, 1'b1});
      sweep(6'd63, 6'd63, 1'b0, 1'b0, 1, 2, "one");
      push6();
      sweep(6'd62, 6'd61, 1'b1, 1'b0, 12, 13, "toggle");
      push6();
      sweep(6'd62, 6'd61, 1'b0, 1'b1, 6, 7, "poke");
      sb.push_back({6'd62, 6'd62, 1'b1}); sb.push_back({6'd62, 6'd63, 1'b0});
      sb.push_back({6'd63, 6'd62, 1'b1}); sb.push_back({6'd63, 6'd63, 1'b0});
      sweep(6'd62, 6'd62, 1'b0, 1'b0, 4, 5, "four");

      push6();
      n_hs = 0;
      @(posedge clk); #1;
      inner_init = 6'd62; outer_init = 6'd61; start = 1'b1; step_ready = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      for (int c = 0; c < 50 && n_hs < 3; c++) @(negedge clk);
      chk("rst_three_steps", n_hs, 3);
      #2 rst = 1'b1;
      #1 chk("rst_async_outputs", {19'd0, step_valid, busy, done, row_first, inner_idx, outer_idx}, 32'd0);
      sb.delete();
      @(negedge clk); rst = 1'b0;
      begin
         bit any_done = 1'b0;
         repeat (4) begin
            @(negedge clk);
            any_done |= done | busy;
         end
         chk("rst_no_done", {31'd0, any_done}, 32'd0);
      end
      push6();
      sweep(6'd62, 6'd61, 1'b0, 1'b0, 6, 7, "after_rst");

`ifdef LOOP_SEQ_ABORT_EN
      sb.push_back({6'd61, 6'd62, 1'b1});
      n_hs = 0;
      @(posedge clk); #1;
      inner_init = 6'd62; outer_init = 6'd61; start = 1'b1; step_ready = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk);
      @(posedge clk); #1; abort = 1'b1;
      @(posedge clk); #1; abort = 1'b0;
      @(negedge clk);
      chk("abort_done", {30'd0, done, aborted}, 32'd3);
      chk("abort_steps", n_hs, 1);
      chk("abort_queue_empty", sb.size(), 0);
      @(negedge clk);
      chk("abort_pulse", {29'd0, done, aborted, busy}, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
